// File: rtl/ariane_pkg.sv
// Minimal frontend/branch-unit types shared by the branch predictor and its bench.
// Only the fields consumed by the predictor are carried in the resolve record.
package ariane_pkg;

  localparam int unsigned VLEN = 64;

  typedef enum logic [2:0] {
    NoCF,
    Branch,
    Jump,
    JumpR,
    Return
  } cf_t;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic [VLEN-1:0] target_address;
    logic            is_taken;
    cf_t             cf_type;
  } bp_resolve_t;

endpackage

// File: rtl/bht_btb_table.sv
// Direct-mapped branch history / target table: learns from resolved branches, answers
// registered-index lookups, and clears its valid bits sequentially on flush.
module bht_btb_table #(
  parameter int unsigned NR_ENTRIES = 64,
  parameter int unsigned TAG_BITS   = 8,
  parameter int unsigned VLEN       = ariane_pkg::VLEN
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    debug_mode_i,
  input  logic                    flush_i,
  input  ariane_pkg::bp_resolve_t resolved_branch_i,
  input  logic [VLEN-1:0]         vpc_i,
  output logic                    lookup_hit_o,
  output logic                    lookup_taken_o,
  output logic [VLEN-1:0]         lookup_target_o,
  output logic                    busy_o
);

  localparam int unsigned IDX = $clog2(NR_ENTRIES);
  localparam logic [IDX-1:0] LastIdx = IDX'(NR_ENTRIES - 1);

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } state_e;

  state_e                state_q, state_d;
  logic [IDX-1:0]        cnt_q, cnt_d;
  logic [NR_ENTRIES-1:0] valid_q, valid_d;
  logic [VLEN-1:0]       vpc_q;

  // Payload storage is never reset; the valid bits alone qualify an entry.
  logic [TAG_BITS-1:0]   tag_q    [NR_ENTRIES];
  logic [1:0]            ctr_q    [NR_ENTRIES];
  logic [VLEN-1:0]       target_q [NR_ENTRIES];

  // Lookup path
  logic [IDX-1:0]      rd_idx;
  logic [TAG_BITS-1:0] rd_tag;
  logic                rd_hit;

  assign rd_idx = vpc_q[IDX:1];
  assign rd_tag = vpc_q[IDX+TAG_BITS:IDX+1];
  assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag) && (state_q == StIdle);

  assign lookup_hit_o    = rd_hit;
  assign lookup_taken_o  = rd_hit && ctr_q[rd_idx][1];
  assign lookup_target_o = rd_hit ? target_q[rd_idx] : '0;
  assign busy_o          = (state_q == StClear);

  // Update path
  logic [IDX-1:0]      wr_idx;
  logic [TAG_BITS-1:0] wr_tag;
  logic                wr_hit;
  logic                upd_ok;
  logic                wr_en;
  logic                wr_tgt_en;
  logic [1:0]          wr_ctr;

  assign wr_idx = resolved_branch_i.pc[IDX:1];
  assign wr_tag = resolved_branch_i.pc[IDX+TAG_BITS:IDX+1];
  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  // A flush in the same cycle takes priority over the update.
  assign upd_ok = resolved_branch_i.valid && !debug_mode_i && (state_q == StIdle) && !flush_i;

  always_comb begin
    wr_en     = 1'b0;
    wr_tgt_en = 1'b0;
    wr_ctr    = ctr_q[wr_idx];
    if (upd_ok) begin
      unique case (resolved_branch_i.cf_type)
        ariane_pkg::Branch: begin
          wr_en = 1'b1;
          if (wr_hit) begin
            if (resolved_branch_i.is_taken) begin
              wr_tgt_en = 1'b1;
              if (ctr_q[wr_idx] != 2'b11) wr_ctr = ctr_q[wr_idx] + 2'b01;
            end else if (ctr_q[wr_idx] != 2'b00) begin
              wr_ctr = ctr_q[wr_idx] - 2'b01;
            end
          end else begin
            wr_tgt_en = 1'b1;
            wr_ctr    = resolved_branch_i.is_taken ? 2'b10 : 2'b01;
          end
        end
        ariane_pkg::JumpR: begin
          wr_en     = 1'b1;
          wr_tgt_en = 1'b1;
          wr_ctr    = 2'b11;
        end
        default: ;
      endcase
    end
  end

  // Flush sequencer and valid-bit next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (flush_i) begin
          state_d = StClear;
          cnt_d   = '0;
        end else if (wr_en) begin
          valid_d[wr_idx] = 1'b1;
        end
      end
      StClear: begin
        valid_d[cnt_q] = 1'b0;
        if (flush_i) begin
          cnt_d = '0;
        end else if (cnt_q == LastIdx) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IDX'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      valid_q <= '0;
      vpc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      vpc_q   <= vpc_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      tag_q[wr_idx] <= wr_tag;
      ctr_q[wr_idx] <= wr_ctr;
      if (wr_tgt_en) target_q[wr_idx] <= resolved_branch_i.target_address;
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{resolved_branch_i.pc[VLEN-1:IDX+TAG_BITS+1], resolved_branch_i.pc[0],
                            vpc_q[VLEN-1:IDX+TAG_BITS+1], vpc_q[0]};

endmodule

// File: tb/tb_bht_btb_table.sv
// Directed bench for bht_btb_table: learning, saturation, aliasing, debug, flush and reset.
module tb_bht_btb_table;
  import ariane_pkg::*;

  logic            clk;
  logic            rst;
  logic            debug_mode;
  logic            flush;
  bp_resolve_t     rb;
  logic [63:0]     vpc;
  logic            hit;
  logic            taken;
  logic [63:0]     target;
  logic            busy;

  int n_checks = 0;
  int n_pass   = 0;

  bht_btb_table #(
    .NR_ENTRIES(64),
    .TAG_BITS  (8),
    .VLEN      (64)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .debug_mode_i     (debug_mode),
    .flush_i          (flush),
    .resolved_branch_i(rb),
    .vpc_i            (vpc),
    .lookup_hit_o     (hit),
    .lookup_taken_o   (taken),
    .lookup_target_o  (target),
    .busy_o           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [63:0] pc);
    vpc = pc;
    tick();
  endtask

  task automatic update(input cf_t cf, input logic [63:0] pc, input logic [63:0] tgt,
                        input logic tk);
    rb.valid          = 1'b1;
    rb.cf_type        = cf;
    rb.pc             = pc;
    rb.target_address = tgt;
    rb.is_taken       = tk;
    tick();
    rb.valid = 1'b0;
  endtask

  task automatic expect_entry(input string name, input logic [63:0] pc, input logic e_hit,
                              input logic e_taken, input logic [63:0] e_tgt);
    lookup(pc);
    check({name, ".hit"}, hit, e_hit);
    check({name, ".taken"}, taken, e_taken);
    check({name, ".target"}, target, e_tgt);
  endtask

  int n;

  initial begin
    rst        = 1'b1;
    debug_mode = 1'b0;
    flush      = 1'b0;
    rb         = '0;
    vpc        = 64'h8000_0010;
    #12;
    check("reset.hit", hit, 1'b0);
    check("reset.taken", taken, 1'b0);
    check("reset.target", target, 64'h0);
    check("reset.busy", busy, 1'b0);
    rst = 1'b0;
    #3;
    expect_entry("cold", 64'h8000_0010, 1'b0, 1'b0, 64'h0);

    // Branch learning and counter saturation
    update(Branch, 64'h8000_0010, 64'h8000_0100, 1'b1);
    expect_entry("br_alloc", 64'h8000_0010, 1'b1, 1'b1, 64'h8000_0100);
    update(Branch, 64'h8000_0010, 64'h0000_dead, 1'b0);
    expect_entry("br_nt1", 64'h8000_0010, 1'b1, 1'b0, 64'h8000_0100);
    update(Branch, 64'h8000_0010, 64'h0000_dead, 1'b0);
    update(Branch, 64'h8000_0010, 64'h0000_dead, 1'b0);
    update(Branch, 64'h8000_0010, 64'h8000_0140, 1'b1);
    expect_entry("br_sat0", 64'h8000_0010, 1'b1, 1'b0, 64'h8000_0140);
    update(Branch, 64'h8000_0010, 64'h8000_0140, 1'b1);
    update(Branch, 64'h8000_0010, 64'h8000_0140, 1'b1);
    update(Branch, 64'h8000_0010, 64'h8000_0140, 1'b1);
    expect_entry("br_ctr3", 64'h8000_0010, 1'b1, 1'b1, 64'h8000_0140);
    update(Branch, 64'h8000_0010, 64'h0, 1'b0);
    expect_entry("br_sat3_nt", 64'h8000_0010, 1'b1, 1'b1, 64'h8000_0140);
    update(Branch, 64'h8000_0010, 64'h0, 1'b0);
    expect_entry("br_ctr1", 64'h8000_0010, 1'b1, 1'b0, 64'h8000_0140);

    // JumpR allocation; other control-flow types must not touch the table
    update(JumpR, 64'h8000_0200, 64'h8000_3000, 1'b1);
    expect_entry("jr", 64'h8000_0200, 1'b1, 1'b1, 64'h8000_3000);
    update(Jump, 64'h8000_0200, 64'h8000_5000, 1'b1);
    update(Return, 64'h8000_0200, 64'h8000_6000, 1'b1);
    update(NoCF, 64'h8000_0200, 64'h8000_7000, 1'b1);
    update(Jump, 64'h8000_0400, 64'h8000_5000, 1'b1);
    expect_entry("jr_keep", 64'h8000_0200, 1'b1, 1'b1, 64'h8000_3000);
    expect_entry("jump_noalloc", 64'h8000_0400, 1'b0, 1'b0, 64'h0);

    // Aliasing: same index (8), different tag
    update(Branch, 64'h8000_0090, 64'h8000_0900, 1'b0);
    expect_entry("alias_new", 64'h8000_0090, 1'b1, 1'b0, 64'h8000_0900);
    expect_entry("alias_old", 64'h8000_0010, 1'b0, 1'b0, 64'h0);

    // Debug mode suppresses updates
    debug_mode = 1'b1;
    update(Branch, 64'h8000_0090, 64'h8000_0a00, 1'b1);
    update(JumpR, 64'h8000_0010, 64'h8000_0b00, 1'b1);
    debug_mode = 1'b0;
    expect_entry("dbg_keep", 64'h8000_0090, 1'b1, 1'b0, 64'h8000_0900);
    expect_entry("dbg_noalloc", 64'h8000_0010, 1'b0, 1'b0, 64'h0);

    // Flush: three live entries (idx 0, 8, 16)
    update(Branch, 64'h8000_0020, 64'h8000_2000, 1'b1);
    expect_entry("pre_flush", 64'h8000_0020, 1'b1, 1'b1, 64'h8000_2000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      if (n == 2) check("flush_hit_forced", hit, 1'b0);
      if (n == 5) begin
        rb.valid = 1'b1; rb.cf_type = JumpR; rb.pc = 64'h8000_0040;
        rb.target_address = 64'h8000_4000; rb.is_taken = 1'b1;
      end else begin
        rb.valid = 1'b0;
      end
      tick();
    end
    rb.valid = 1'b0;
    check("flush_len", 64'(n), 64'd64);
    expect_entry("flush_e0", 64'h8000_0200, 1'b0, 1'b0, 64'h0);
    expect_entry("flush_e8", 64'h8000_0090, 1'b0, 1'b0, 64'h0);
    expect_entry("flush_e16", 64'h8000_0020, 1'b0, 1'b0, 64'h0);
    expect_entry("flush_drop", 64'h8000_0040, 1'b0, 1'b0, 64'h0);
    update(Branch, 64'h8000_0020, 64'h8000_2200, 1'b1);
    expect_entry("post_flush_upd", 64'h8000_0020, 1'b1, 1'b1, 64'h8000_2200);

    // Re-pulse flush in busy cycle 30
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n = 0;
    while (busy && n < 300) begin
      n++;
      flush = (n == 30);
      tick();
    end
    flush = 1'b0;
    check("reflush_len", 64'(n), 64'd94);
    expect_entry("reflush_miss", 64'h8000_0020, 1'b0, 1'b0, 64'h0);

    // Read/write collision on index 8
    update(Branch, 64'h8000_0010, 64'h8000_0110, 1'b1);
    lookup(64'h8000_0010);
    rb.valid = 1'b1; rb.cf_type = JumpR; rb.pc = 64'h8000_0010;
    rb.target_address = 64'h8000_7000; rb.is_taken = 1'b1;
    #1;
    check("coll_old", target, 64'h8000_0110);
    tick();
    rb.valid = 1'b0;
    check("coll_new", target, 64'h8000_7000);
    check("coll_new_taken", taken, 1'b1);

    // Reset in the middle of a clear
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (10) tick();
    check("mid_clear_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_hit", hit, 1'b0);
    check("rst_target", target, 64'h0);
    #2;
    rst = 1'b0;
    expect_entry("rst_miss", 64'h8000_0010, 1'b0, 1'b0, 64'h0);
    check("rst_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bht_btb_table.md
# bht_btb_table

Branch history and target table that consumes the `resolved_branch_o` stream emitted by the branch unit and serves per-fetch predictions to the frontend. Each entry is direct-mapped and holds a valid bit, a partial tag, a 2-bit saturating counter and a target address. The table learns conditional branches and indirect jumps, answers lookups with one-cycle registered latency, and supports a multi-cycle sequential flush for fence.i and debug entry.

## Interface
- `NR_ENTRIES`, default 64: number of entries; power of two, ≥ 4.
- `TAG_BITS`, default 8: stored partial tag width.
- `VLEN`, default 64: virtual address width; must equal `riscv::VLEN`.
- `clk_i` in, 1: clock; all state changes on the rising edge.
- `rst_i` in, 1: reset, asynchronous, active-high.
- `debug_mode_i` in, 1: when high, updates are suppressed; lookups still operate.
- `flush_i` in, 1: single-cycle pulse that starts the sequential clear.
- `resolved_branch_i` in, `ariane_pkg::bp_resolve_t`: uses the fields `valid`, `pc`, `target_address`, `is_taken` and `cf_type`.
- `vpc_i` in, VLEN: fetch PC to look up; sampled every cycle.
- `lookup_hit_o` out, 1: the registered lookup matched a valid entry.
- `lookup_taken_o` out, 1: predict taken (hit && ctr[1]).
- `lookup_target_o` out, VLEN: predicted target from the hitting entry; 0 on a miss.
- `busy_o` out, 1: flush in progress.

## Operation
- Index: `pc[IDX+0:1]`, where IDX = log2(NR_ENTRIES). Bit 0 is ignored because compressed instructions are supported.
- Tag: `pc[IDX+TAG_BITS:IDX+1]`.
- An update is accepted when `resolved_branch_i.valid`, `!debug_mode_i` and state == IDLE all hold.
- Update for `cf_type == Branch`:
  - Hit (entry valid and tag equal): ctr increments on taken and decrements on not-taken, saturating at 3 and 0. The target is written only when `is_taken`.
  - Miss: the entry is allocated or replaced. valid=1, tag written, ctr = taken ? 2'b10 : 2'b01, target = `target_address`.
- Update for `cf_type == JumpR`: allocate or overwrite with ctr=2'b11 and target = `target_address`, regardless of hit.
- `cf_type` NoCF, Jump or Return: no update.
- Lookup: `vpc_i` is registered at edge N. The entry is read combinationally from the registered index, and the outputs are valid during cycle N+1.
- Read/write collision: if an update at edge N+1 writes the index being read in cycle N+1, the outputs reflect the pre-update entry. The new contents are visible to a lookup sampled at edge N+1 or later.
- FSM states:
  - IDLE → CLEAR on `flush_i`. The clear counter loads 0.
  - CLEAR: each cycle clears `valid[cnt]` and increments cnt. When cnt == NR_ENTRIES-1, that entry is cleared and the FSM returns to IDLE.
  - `flush_i` asserted during CLEAR restarts cnt at 0.
- In CLEAR: `busy_o`=1, updates are dropped, and `lookup_hit_o`/`lookup_taken_o` are forced to 0.
- Counter and target storage are not cleared by flush or reset; only the valid bits are.

## Timing
- Reset values:
  - All valid bits 0; FSM in IDLE; clear counter 0.
  - `lookup_hit_o`=0, `lookup_taken_o`=0, `lookup_target_o`=0, `busy_o`=0.
- Lookup latency: 1 cycle from `vpc_i` to the outputs.
- Update latency: the entry is written at the edge where the update is accepted. It is observable by a lookup whose `vpc_i` is sampled at that same edge, with outputs one cycle later.
- Flush duration: `busy_o` rises the cycle after `flush_i` and stays high for exactly NR_ENTRIES cycles if not restarted. The first update accepted after a flush is the one presented in the cycle after `busy_o` falls.
- Reset mid-CLEAR: immediate return to IDLE, all valid bits cleared, `busy_o`=0.
- Simultaneous `flush_i` and update in IDLE: the flush wins and the update is dropped.

## Test plan
- Cold lookup: after reset, `vpc_i`=0x8000_0010 → `lookup_hit_o`=0, `lookup_taken_o`=0, `lookup_target_o`=0 one cycle later.
- Branch learning:
  - Branch at pc 0x8000_0010, taken, target 0x8000_0100 → lookup gives hit=1, taken=1, target=0x8000_0100 (ctr=2).
  - Two further not-taken resolutions → ctr=0 and taken=0 with hit=1.
  - Four taken resolutions → ctr saturates at 3.
- JumpR and ignored types:
  - JumpR at pc 0x8000_0200, target 0x8000_3000, is_taken=1 → hit, taken=1, target 0x8000_3000.
  - An identical update with `cf_type`=Jump or Return leaves the entry unchanged.
- Aliasing and debug:
  - Two branches sharing an index with different tags (pc 0x8000_0010 and 0x8000_0090 with NR_ENTRIES=64) → the second replaces the first, and a lookup of the first misses.
  - Updates with `debug_mode_i`=1 leave the table unchanged.
- Flush:
  - After populating 3 entries, pulse `flush_i` → `busy_o` is high for 64 cycles, updates during that window are dropped, and all lookups miss afterwards.
  - A re-pulse at cycle 30 extends `busy_o` to 30+64 cycles.
- Collision and reset:
  - Lookup and update of the same index in one cycle → old entry returned, new entry returned on the next lookup.
  - `rst_i` asserted mid-CLEAR → `busy_o`=0 and all misses immediately.
